eth_pause_req_gen: RTL and testbench

Flow-control request source for the 10G Ethernet design example. It watches the receive-buffer fill level and software pulses, and produces the 2-bit pause request code. That code feeds the timing adapter in front of the MAC pause interface. The adapter cannot backpressure, so this block drives a free-running code every cycle with no handshake. Each request is a fixed-length pulse; the pause state is held with hysteresis, and XOFF is refreshed while congestion persists.

---
 rtl/eth_pause_pkg.sv | 28 ++
 rtl/eth_pause_pulse_shaper.sv | 73 +++++++
 rtl/eth_pause_req_gen.sv | 155 +++++++++++++++
 tb/tb_eth_pause_req_gen.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pause_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_pause_pkg
// Description : Shared pause-code constants, FSM state type and helpers for
//               the pause request generator.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_pause_pkg;

  // Pause request codes presented to the MAC timing adapter.
  // The code 2'b11 is never driven.
  localparam logic [1:0] PAUSE_IDLE = 2'b00;
  localparam logic [1:0] PAUSE_XON  = 2'b01;
  localparam logic [1:0] PAUSE_XOFF = 2'b10;

  // Flow-control state.
  typedef enum logic [0:0] {
    RUN    = 1'b0,
    PAUSED = 1'b1
  } pause_state_e;

  // Saturating 16-bit increment used by the statistics counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

endpackage : eth_pause_pkg
`default_nettype wire

// File: rtl/eth_pause_pulse_shaper.sv
`default_nettype none
// ============================================================================
// Module      : eth_pause_pulse_shaper
// Description : Turns single-cycle pause requests into fixed-length code
//               pulses followed by one idle gap cycle. A request that
//               arrives while a pulse or gap is in progress waits in a
//               one-deep pending slot; a newer request replaces it.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_pause_pulse_shaper
  import eth_pause_pkg::*;
#(
  parameter int PULSE_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  output logic [1:0] o_out_data,
  output logic       o_xoff_start
);

  localparam int               c_cnt_w    = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [c_cnt_w-1:0] c_len_m1 = c_cnt_w'(PULSE_LEN - 1);

  logic [1:0]         r_code;
  logic [c_cnt_w-1:0] r_left;
  logic [1:0]         r_pend;

  logic               w_free;
  logic [1:0]         w_cand;
  logic               w_launch;

  // The shaper can start a pulse only when the registered code is idle.
  // The cycle right after a pulse shows idle too, so that cycle is the
  // mandatory gap: a pulse can never start at the edge that ends the
  // previous one.
  assign w_free   = (r_code == PAUSE_IDLE);

  // A request arriving this cycle is newer than anything pending.
  assign w_cand   = (i_req != PAUSE_IDLE) ? i_req : r_pend;
  assign w_launch = w_free && (w_cand != PAUSE_IDLE);

  // Start-of-XOFF strobe, valid at the edge where the XOFF code is loaded.
  assign o_xoff_start = w_launch && (w_cand == PAUSE_XOFF);

  assign o_out_data = r_code;

  // Pulse length counting, gap insertion and pending-slot management.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_code <= PAUSE_IDLE;
      r_left <= '0;
      r_pend <= PAUSE_IDLE;
    end else if (w_launch) begin
      r_code <= w_cand;
      r_left <= c_len_m1;
      r_pend <= PAUSE_IDLE;
    end else begin
      if (i_req != PAUSE_IDLE) begin
        r_pend <= i_req;
      end
      if (r_code != PAUSE_IDLE) begin
        if (r_left == '0) begin
          r_code <= PAUSE_IDLE;
        end else begin
          r_left <= r_left - 1'b1;
        end
      end
    end
  end

endmodule : eth_pause_pulse_shaper
`default_nettype wire

// File: rtl/eth_pause_req_gen.sv
`default_nettype none
// ============================================================================
// Module      : eth_pause_req_gen
// Description : Pause request source for the 10G Ethernet example. Watches
//               the receive-buffer fill level and software strobes, holds a
//               hysteretic pause state, refreshes XOFF while paused and
//               drives a free-running 2-bit pause code.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_pause_req_gen
  import eth_pause_pkg::*;
#(
  parameter int LEVEL_W        = 16,
  parameter int HI_WM          = 1536,
  parameter int LO_WM          = 512,
  parameter int REFRESH_CYCLES = 65536,
  parameter int PULSE_LEN      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_enable,
  input  logic [LEVEL_W-1:0] i_fill_level,
  input  logic               i_sw_xoff,
  input  logic               i_sw_xon,
  output logic [1:0]         o_out_data,
  output logic               o_pause_active,
  output logic [15:0]        o_xoff_count
);

  localparam logic [LEVEL_W-1:0] c_hi_wm = LEVEL_W'(HI_WM);
  localparam logic [LEVEL_W-1:0] c_lo_wm = LEVEL_W'(LO_WM);

  // Refresh counter holds REFRESH_CYCLES-1 at most.
  localparam int                   c_refresh_w    = $clog2(REFRESH_CYCLES);
  localparam logic [c_refresh_w-1:0] c_refresh_load = c_refresh_w'(REFRESH_CYCLES - 1);

  logic [LEVEL_W-1:0]     r_lvl;
  pause_state_e           r_state;
  logic                   r_sw_entry;
  logic                   r_en_prev;
  logic [c_refresh_w-1:0] r_refresh;
  logic [15:0]            r_xoff_count;

  pause_state_e           w_state_nxt;
  logic                   w_sw_entry_nxt;
  logic [1:0]             w_req;
  logic                   w_above_hi;
  logic                   w_below_lo;
  logic                   w_en_fall;
  logic                   w_refresh_ok;
  logic                   w_xoff_start;

  // Compare against the registered level only, so the watermark decision
  // is made on one consistent sample.
  assign w_above_hi = (r_lvl > c_hi_wm);
  assign w_below_lo = (r_lvl < c_lo_wm);
  assign w_en_fall  = r_en_prev && !i_enable;

  // Refresh is due once the counter has run out. A software-entered pause
  // keeps refreshing regardless of level; an automatic one only while the
  // buffer has not drained below the low watermark.
  assign w_refresh_ok = (r_refresh == '0) && (!w_below_lo || r_sw_entry);

  // Input sampling: fill level register and enable history for fall detect.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lvl     <= '0;
      r_en_prev <= 1'b0;
    end else begin
      r_lvl     <= i_fill_level;
      r_en_prev <= i_enable;
    end
  end

  // FSM state register and the "entered by software" qualifier.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= RUN;
      r_sw_entry <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sw_entry <= w_sw_entry_nxt;
    end
  end

  // Next-state and request decode. A software XOFF in the paused state
  // blocks every exit path; paired with XON (or at refresh time) it
  // re-issues XOFF.
  always_comb begin
    w_state_nxt    = r_state;
    w_sw_entry_nxt = r_sw_entry;
    w_req          = PAUSE_IDLE;
    case (r_state)
      RUN: begin
        if ((i_enable && w_above_hi) || i_sw_xoff) begin
          w_state_nxt    = PAUSED;
          w_sw_entry_nxt = i_sw_xoff;
          w_req          = PAUSE_XOFF;
        end
      end
      PAUSED: begin
        if (i_sw_xoff) begin
          if (i_sw_xon || w_refresh_ok) begin
            w_req = PAUSE_XOFF;
          end
        end else if ((i_enable && w_below_lo) || i_sw_xon || w_en_fall) begin
          w_state_nxt    = RUN;
          w_sw_entry_nxt = 1'b0;
          w_req          = PAUSE_XON;
        end else if (w_refresh_ok) begin
          w_req = PAUSE_XOFF;
        end
      end
      default: begin
        w_state_nxt    = RUN;
        w_sw_entry_nxt = 1'b0;
      end
    endcase
  end

  // Refresh down-counter: reloaded on every XOFF pulse start, parks at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_refresh <= '0;
    end else if (w_xoff_start) begin
      r_refresh <= c_refresh_load;
    end else if (r_refresh != '0) begin
      r_refresh <= r_refresh - 1'b1;
    end
  end

  // Saturating count of XOFF pulses actually issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_xoff_count <= '0;
    end else if (w_xoff_start) begin
      r_xoff_count <= sat_inc16(r_xoff_count);
    end
  end

  eth_pause_pulse_shaper #(
    .PULSE_LEN (PULSE_LEN)
  ) u_shaper (
    .clk          (clk),
    .reset        (reset),
    .i_req        (w_req),
    .o_out_data   (o_out_data),
    .o_xoff_start (w_xoff_start)
  );

  assign o_pause_active = (r_state == PAUSED);
  assign o_xoff_count   = r_xoff_count;

endmodule : eth_pause_req_gen
`default_nettype wire

// File: tb/tb_eth_pause_req_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_eth_pause_req_gen
// Description : Bench for eth_pause_req_gen. Instance A (default refresh
//               period) runs a directed vector table; instance B (16-cycle
//               refresh) runs a refresh sequence and random stimulus against
//               a queue/timestamp reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_pause_req_gen;

  localparam int HI_WM     = 1536;
  localparam int LO_WM     = 512;
  localparam int PULSE_LEN = 4;
  localparam int REF_B     = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- instance A ----------------
  logic        a_reset = 1'b1, a_en = 1'b1, a_sx = 1'b0, a_sn = 1'b0;
  logic [15:0] a_fill = '0;
  logic [1:0]  a_out;
  logic        a_pause;
  logic [15:0] a_cnt;

  eth_pause_req_gen #(
    .LEVEL_W(16), .HI_WM(HI_WM), .LO_WM(LO_WM),
    .REFRESH_CYCLES(65536), .PULSE_LEN(PULSE_LEN)
  ) u_dut_a (
    .clk(clk), .reset(a_reset), .i_enable(a_en), .i_fill_level(a_fill),
    .i_sw_xoff(a_sx), .i_sw_xon(a_sn),
    .o_out_data(a_out), .o_pause_active(a_pause), .o_xoff_count(a_cnt)
  );

  // ---------------- instance B ----------------
  logic        b_reset = 1'b1, b_en = 1'b1, b_sx = 1'b0, b_sn = 1'b0;
  logic [15:0] b_fill = '0;
  logic [1:0]  b_out;
  logic        b_pause;
  logic [15:0] b_cnt;

  eth_pause_req_gen #(
    .LEVEL_W(16), .HI_WM(HI_WM), .LO_WM(LO_WM),
    .REFRESH_CYCLES(REF_B), .PULSE_LEN(PULSE_LEN)
  ) u_dut_b (
    .clk(clk), .reset(b_reset), .i_enable(b_en), .i_fill_level(b_fill),
    .i_sw_xoff(b_sx), .i_sw_xon(b_sn),
    .o_out_data(b_out), .o_pause_active(b_pause), .o_xoff_count(b_cnt)
  );

  task automatic check(input string name, input int idx,
                       input logic [1:0] got_o, input logic got_p, input logic [15:0] got_c,
                       input int exp_o, input int exp_p, input int exp_c);
    checks++;
    if (got_o !== 2'(exp_o) || got_p !== 1'(exp_p) || got_c !== 16'(exp_c)) begin
      errors++;
      $display("FAIL %s[%0d] got out=%0d pause=%0d cnt=%0d want out=%0d pause=%0d cnt=%0d",
               name, idx, got_o, got_p, got_c, exp_o, exp_p, exp_c);
    end
  endtask

  // ---------------- reference model for instance B ----------------
  // Timestamps for refresh, a queue of scheduled output codes for the shaper.
  bit m_paused = 0, m_sw = 0, m_prev_en = 0;
  int m_lvl = 0, m_t = 0, m_last = -REF_B, m_pend = 0, m_cnt = 0, m_out = 0;
  int m_q[$];

  always @(posedge clk) begin : model
    int  req, cand;
    bit  above, below, fall, due;
    if (b_reset) begin
      m_paused = 0; m_sw = 0; m_prev_en = 0; m_lvl = 0; m_pend = 0;
      m_cnt = 0; m_out = 0; m_t = 0; m_last = -REF_B; m_q.delete();
    end else begin
      above = (m_lvl > HI_WM);
      below = (m_lvl < LO_WM);
      fall  = m_prev_en && !b_en;
      due   = ((m_t - m_last) >= REF_B) && (!below || m_sw);
      req   = 0;
      if (!m_paused) begin
        if ((b_en && above) || b_sx) begin req = 2; m_paused = 1; m_sw = b_sx; end
      end else if (b_sx) begin
        if (b_sn || due) req = 2;
      end else if ((b_en && below) || b_sn || fall) begin
        req = 1; m_paused = 0; m_sw = 0;
      end else if (due) begin
        req = 2;
      end
      cand = (req != 0) ? req : m_pend;
      if (m_q.size() == 0 && cand != 0) begin
        repeat (PULSE_LEN) m_q.push_back(cand);
        m_q.push_back(0);
        m_pend = 0;
        if (cand == 2) begin
          if (m_cnt < 65535) m_cnt++;
          m_last = m_t;
        end
      end else if (req != 0) begin
        m_pend = req;
      end
      m_out = (m_q.size() != 0) ? m_q.pop_front() : 0;
      m_lvl = int'(b_fill);
      m_prev_en = b_en;
      m_t++;
    end
  end

  function automatic logic [15:0] pick_level();
    case ($urandom_range(0, 5))
      0:       return 16'($urandom_range(0, 510));
      1:       return 16'($urandom_range(511, 513));
      2:       return 16'($urandom_range(514, 1534));
      3:       return 16'($urandom_range(1535, 1537));
      4:       return 16'($urandom_range(1538, 4000));
      default: return 16'hFFFF;
    endcase
  endfunction

  // ---------------- directed vector table for instance A ----------------
  typedef struct {
    int reps; int rst; int en; int fill; int sx; int sn;
    int out; int pause; int cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int reps, input int rst, input int en, input int fill,
                     input int sx, input int sn, input int out, input int pause, input int cnt);
    vec_t v;
    v = '{reps, rst, en, fill, sx, sn, out, pause, cnt};
    tbl.push_back(v);
  endtask

  initial begin
    // reps rst en fill  sx sn | out pause cnt
    add( 3, 1, 1,    0, 0, 0,   0, 0, 0);   // reset state
    add( 9, 0, 1,    0, 0, 0,   0, 0, 0);   // edges 1..9
    add( 1, 0, 1, 1537, 0, 0,   0, 0, 0);   // edge 10: level registered only
    add( 4, 0, 1, 1537, 0, 0,   2, 1, 1);   // XOFF cycles 11..14
    add(25, 0, 1, 1537, 0, 0,   0, 1, 1);
    add( 1, 0, 1,  511, 0, 0,   0, 1, 1);   // edge 40
    add( 4, 0, 1,  511, 0, 0,   1, 0, 1);   // XON cycles 41..44
    add( 6, 0, 1,  511, 0, 0,   0, 0, 1);
    add( 1, 0, 1, 1000, 1, 1,   2, 1, 2);   // sw_xoff+sw_xon in RUN: XOFF wins
    add( 3, 0, 1, 1000, 0, 0,   2, 1, 2);
    add( 1, 0, 1, 1000, 0, 0,   0, 1, 2);   // gap
    add( 1, 0, 1, 1000, 0, 1,   1, 0, 2);   // sw_xon after gap
    add( 3, 0, 1, 1000, 0, 0,   1, 0, 2);
    add( 2, 0, 1, 1000, 0, 0,   0, 0, 2);
    add( 1, 0, 1, 1000, 1, 0,   2, 1, 3);   // sw_xoff then sw_xon two later
    add( 1, 0, 1, 1000, 0, 0,   2, 1, 3);
    add( 1, 0, 1, 1000, 0, 1,   2, 0, 3);
    add( 1, 0, 1, 1000, 0, 0,   2, 0, 3);
    add( 1, 0, 1, 1000, 0, 0,   0, 0, 3);   // gap
    add( 4, 0, 1, 1000, 0, 0,   1, 0, 3);   // pending XON
    add( 2, 0, 1, 1000, 0, 0,   0, 0, 3);
    add( 1, 0, 1, 1000, 1, 0,   2, 1, 4);   // reset mid-pulse, XON pending
    add( 1, 0, 1, 1000, 0, 1,   2, 0, 4);
    add( 1, 1, 1, 1000, 0, 0,   0, 0, 0);
    add( 8, 0, 1, 1000, 0, 0,   0, 0, 0);   // pending XON discarded
    add( 1, 0, 1, 2000, 0, 0,   0, 0, 0);   // enable drop while paused
    add( 4, 0, 1, 2000, 0, 0,   2, 1, 1);
    add( 1, 0, 1, 2000, 0, 0,   0, 1, 1);
    add( 1, 0, 0, 2000, 0, 0,   1, 0, 1);
    add( 3, 0, 0, 2000, 0, 0,   1, 0, 1);
    add( 8, 0, 0, 1536, 0, 0,   0, 0, 1);
    add( 5, 0, 1, 1536, 0, 0,   0, 0, 1);   // level == HI_WM: no pause
    add( 1, 0, 1, 1537, 0, 0,   0, 0, 1);
    add( 4, 0, 1, 1537, 0, 0,   2, 1, 2);
    add( 6, 0, 1,  512, 0, 0,   0, 1, 2);   // level == LO_WM: stay paused
    add( 1, 0, 1,  511, 0, 0,   0, 1, 2);
    add( 4, 0, 1,  511, 0, 0,   1, 0, 2);
    add( 2, 0, 1,  511, 0, 0,   0, 0, 2);
    add( 1, 0, 1,  511, 0, 1,   0, 0, 2);   // sw_xon in RUN ignored
    add( 4, 0, 1,  511, 0, 0,   0, 0, 2);

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        a_reset = 1'(tbl[i].rst);
        a_en    = 1'(tbl[i].en);
        a_fill  = 16'(tbl[i].fill);
        a_sx    = 1'(tbl[i].sx);
        a_sn    = 1'(tbl[i].sn);
        @(posedge clk); @(negedge clk);
        check("vec", i, a_out, a_pause, a_cnt, tbl[i].out, tbl[i].pause, tbl[i].cnt);
      end
    end

    // Refresh sequence on B: XOFF every REF_B cycles at a mid level, no XON.
    b_reset = 1'b1; b_en = 1'b1; b_fill = '0; b_sx = 1'b0; b_sn = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    b_reset = 1'b0;
    b_fill  = 16'd1537;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    check("refresh", 0, b_out, b_pause, b_cnt, 2, 1, 1);
    b_fill = 16'd1000;
    for (int c = 1; c < 70; c++) begin
      @(posedge clk); @(negedge clk);
      check("refresh", c, b_out, b_pause, b_cnt,
            ((c % REF_B) < PULSE_LEN) ? 2 : 0, 1, (c / REF_B) + 1);
    end

    // Random phase on B against the reference model.
    for (int i = 0; i < 3000; i++) begin
      b_reset = (i == 0) || ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 49) == 0) b_en = ~b_en;
      if ($urandom_range(0, 15) == 0) b_fill = pick_level();
      b_sx = ($urandom_range(0, 39) == 0);
      b_sn = ($urandom_range(0, 39) == 0);
      @(posedge clk); @(negedge clk);
      check("random", i, b_out, b_pause, b_cnt, m_out, int'(m_paused), m_cnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_eth_pause_req_gen
`default_nettype wire
